// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter with open-drain clock/data enables.
// Define PS2_TX_RESEND_EN to retry a NACKed or timed-out byte up to two more times.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txValid,
    input  logic [7:0] txData,
    output logic       txReady,
    output logic       txDone,
    output logic       txError,
    output logic       busy,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe
);

    localparam int MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, ERROR
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         edge_reg, edge_next;
    logic               data_oe_reg, data_oe_next;
    logic [7:0]         data_reg;
    logic               parity_reg;
    logic               clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic               data_meta_reg, data_sync_reg;
    logic               fall;
    logic               accept;
    logic               timeout;
`ifdef PS2_TX_RESEND_EN
    logic [1:0]         retry_reg, retry_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            clk_prev_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg  <= ps2ClkIn;
            clk_sync_reg  <= clk_meta_reg;
            clk_prev_reg  <= clk_sync_reg;
            data_meta_reg <= ps2DataIn;
            data_sync_reg <= data_meta_reg;
        end
    end

    assign fall    = clk_prev_reg & ~clk_sync_reg;
    assign accept  = txValid & (state_reg == IDLE);
    assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            edge_reg    <= '0;
            data_oe_reg <= 1'b0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            edge_reg    <= edge_next;
            data_oe_reg <= data_oe_next;
`ifdef PS2_TX_RESEND_EN
            retry_reg   <= retry_next;
`endif
            if (accept) begin
                data_reg   <= txData;
                parity_reg <= ~^txData;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        edge_next    = edge_reg;
        data_oe_next = data_oe_reg;
        txDone       = 1'b0;
        txError      = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_next   = retry_reg;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                edge_next    = '0;
                data_oe_next = 1'b0;
                if (accept) begin
                    state_next = INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_next = '0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = START;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            START: begin
                if (cnt_reg == CNT_W'(START_CYCLES - 1)) begin
                    // Start bit stays driven until the device's first falling edge.
                    cnt_next     = '0;
                    edge_next    = '0;
                    data_oe_next = 1'b1;
                    state_next   = SEND;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SEND: begin
                if (timeout) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (fall) begin
                        edge_next = edge_reg + 4'd1;
                        if (edge_reg < 4'd8) begin
                            data_oe_next = ~data_reg[edge_reg[2:0]];
                        end else if (edge_reg == 4'd8) begin
                            data_oe_next = ~parity_reg;
                        end else begin
                            data_oe_next = 1'b0;
                            state_next   = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (timeout) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (fall) begin
                        state_next = data_sync_reg ? ERROR : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (clk_sync_reg && data_sync_reg) begin
                        txDone     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            ERROR: begin
                cnt_next     = '0;
                data_oe_next = 1'b0;
`ifdef PS2_TX_RESEND_EN
                if (retry_reg != 2'd2) begin
                    retry_next = retry_reg + 2'd1;
                    state_next = INHIBIT;
                end else begin
                    txError    = 1'b1;
                    state_next = IDLE;
                end
`else
                txError    = 1'b1;
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Line enables decode straight from state so reset and error release them at once.
    assign txReady   = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign ps2ClkOe  = (state_reg == INHIBIT) || (state_reg == START);
    assign ps2DataOe = (state_reg == START) || ((state_reg == SEND) && data_oe_reg);

endmodule
